sdram_host_bridge: RTL and testbench
====================================

Name: sdram_host_bridge

Overview:
- Upstream front end for the 16-bit SDRAM controller. Accepts 32-bit word read/write requests on a valid/ready interface.
- Splits each request into two sequential 16-bit controller accesses using the controller's rd_enable/wr_enable/busy handshake.
- Reassembles read data and returns one response per request, including an error flag when the controller fails to accept an access.

Parameters:
- HADDR_WIDTH, 24: controller halfword address width (row+col+bank).
- ACK_TIMEOUT, 16: max cycles to wait for sdram_busy to rise after an enable pulse.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept request
- req_we  in  1  1=write, 0=read
- req_addr  in  HADDR_WIDTH-1  32-bit word address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data, valid with rsp_valid on reads
- rsp_err  out  1  access timed out, valid with rsp_valid
- sdram_haddr  out  HADDR_WIDTH  to controller haddr
- sdram_wdata  out  16  to controller data_input
- sdram_rdata  in  16  from controller data_output
- sdram_busy  in  1  controller busy
- sdram_rd_enable  out  1  controller read strobe
- sdram_wr_enable  out  1  controller write strobe

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n). All flops clear immediately on rst_n low.
- Reset values:
  - state=IDLE; sdram_rd_enable=sdram_wr_enable=0; rsp_valid=0; rsp_err=0.
  - rsp_rdata=0, sdram_haddr=0, sdram_wdata=0.
  - req_ready=1 (combinational, high only in IDLE).
- Controller contract relied upon:
  - The controller samples an enable on a clk edge when busy is low.
  - It raises busy within ACK_TIMEOUT cycles.
  - It drops busy when the access completes; sdram_rdata is valid in the first cycle busy is low again.
- States: IDLE, ISSUE_LO, WAIT_ACK_LO, WAIT_DONE_LO, ISSUE_HI, WAIT_ACK_HI, WAIT_DONE_HI, RESP.
- IDLE:
  - On req_valid&req_ready, latch req_we, req_addr and req_wdata; go to ISSUE_LO.
- ISSUE_x:
  - While sdram_busy=1, hold with no enable. This covers refresh.
  - When sdram_busy=0, on the next edge drive the following and go to WAIT_ACK_x with the timeout counter cleared:
    - sdram_haddr={addr,0} for LO, {addr,1} for HI;
    - sdram_wdata=wdata[15:0] for LO, wdata[31:16] for HI;
    - the enable matching we.
  - The enable is high for exactly one cycle. haddr and wdata stay stable until the next ISSUE.
- WAIT_ACK_x:
  - sdram_busy=1 -> WAIT_DONE_x.
  - Otherwise increment the counter. When the count reaches ACK_TIMEOUT, set rsp_err=1 and go to RESP; the HI half is skipped.
- WAIT_DONE_x:
  - On sdram_busy=0: for reads capture sdram_rdata into rdata[15:0] (LO) or rdata[31:16] (HI).
  - Then go to ISSUE_HI from LO, or to RESP from HI.
- RESP:
  - rsp_valid=1 for one cycle, with rsp_rdata and rsp_err.
  - On writes rsp_rdata holds its previous value. On error, rsp_rdata holds partial data.
  - Next cycle: IDLE, and rsp_err clears.
- Throughput:
  - Only one request is outstanding; no new accept in the RESP cycle.
  - Back-to-back accept is possible in the first IDLE cycle after RESP.
- Minimum latency: accept edge to rsp_valid = 2 × (issue + ack + done) + 1 cycles, controller-dependent.
- Counter width: clog2(ACK_TIMEOUT+1); it saturates and does not wrap.
- Reset mid-operation: the in-flight access is abandoned, with no response and the enables forced low at once. The controller's own reset is the system's concern.

Test Plan:
- Write req_addr=0x12345, wdata=0xDEADBEEF, with the controller model busy 5 cycles per access. Required:
  - wr pulse 1: haddr=0x2468A, wdata=0xBEEF;
  - wr pulse 2: haddr=0x2468B, wdata=0xDEAD;
  - each pulse exactly 1 cycle;
  - one rsp_valid with rsp_err=0.
- Read req_addr=0x00010, model returning 0x1111 then 0x2222 -> rd pulses at haddr 0x20/0x21; rsp_rdata=0x22221111, rsp_err=0.
- Hold sdram_busy=1 for 20 cycles (refresh) after accept -> no enable while busy; the first enable comes on the edge after busy falls; data is correct.
- Model never raises busy, ACK_TIMEOUT=16 -> exactly one rd pulse; rsp_valid with rsp_err=1 about 17 cycles later; no HI access; req_ready returns to 1.
- Assert rst_n low during WAIT_DONE_HI -> enables, rsp_valid and rsp_err go 0 asynchronously; req_ready=1 after release; no spurious rsp_valid.
- Hold req_valid high across two requests -> the second is accepted only in the cycle after the first rsp_valid; the responses come in order.

Source files
------------

// File: rtl/sdram_host_bridge_if.sv
// Host-side request/response bus of the SDRAM host bridge: one 32-bit word
// request in, one response out per request.
interface sdram_host_bridge_if #(
  parameter int HADDR_WIDTH = 24
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [HADDR_WIDTH-2:0] req_addr;
  logic [31:0]            req_wdata;
  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sdram_host_bridge.sv
// Splits 32-bit host word requests into two 16-bit accesses on the SDRAM
// controller's enable/busy handshake and reassembles one response per request.
module sdram_host_bridge #(
  parameter int HADDR_WIDTH = 24,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sdram_host_bridge_if.slave     host,
  output logic [HADDR_WIDTH-1:0] sdram_haddr,
  output logic [15:0]            sdram_wdata,
  input  logic [15:0]            sdram_rdata,
  input  logic                   sdram_busy,
  output logic                   sdram_rd_enable,
  output logic                   sdram_wr_enable
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ACK_MAX = CNT_W'(ACK_TIMEOUT);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ISSUE_LO     = 3'd1;
  localparam logic [2:0] WAIT_ACK_LO  = 3'd2;
  localparam logic [2:0] WAIT_DONE_LO = 3'd3;
  localparam logic [2:0] ISSUE_HI     = 3'd4;
  localparam logic [2:0] WAIT_ACK_HI  = 3'd5;
  localparam logic [2:0] WAIT_DONE_HI = 3'd6;
  localparam logic [2:0] RESP         = 3'd7;

  logic [2:0]             state;
  logic                   we_q;
  logic [HADDR_WIDTH-2:0] addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   err_q;
  logic [CNT_W-1:0]       ack_cnt;
  logic                   issue_hi;
  logic                   ack_hi;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ACK_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign issue_hi = (state == ISSUE_HI);
  assign ack_hi   = (state == WAIT_ACK_HI);

  assign host.req_ready = (state == IDLE);
  assign host.rsp_valid = (state == RESP);
  assign host.rsp_rdata = rdata_q;
  assign host.rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      ack_cnt         <= '0;
      sdram_haddr     <= '0;
      sdram_wdata     <= '0;
      sdram_rd_enable <= 1'b0;
      sdram_wr_enable <= 1'b0;
    end else begin
      // Enables default low so every strobe lasts exactly one cycle.
      sdram_rd_enable <= 1'b0;
      sdram_wr_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (host.req_valid) begin
            we_q    <= host.req_we;
            addr_q  <= host.req_addr;
            wdata_q <= host.req_wdata;
            state   <= ISSUE_LO;
          end
        end
        ISSUE_LO, ISSUE_HI: begin
          // A busy controller here is usually refresh; wait it out silently.
          if (!sdram_busy) begin
            sdram_haddr     <= {addr_q, issue_hi};
            sdram_wdata     <= issue_hi ? wdata_q[31:16] : wdata_q[15:0];
            sdram_rd_enable <= !we_q;
            sdram_wr_enable <= we_q;
            ack_cnt         <= '0;
            state           <= issue_hi ? WAIT_ACK_HI : WAIT_ACK_LO;
          end
        end
        WAIT_ACK_LO, WAIT_ACK_HI: begin
          if (sdram_busy) begin
            state <= ack_hi ? WAIT_DONE_HI : WAIT_DONE_LO;
          end else begin
            ack_cnt <= sat_inc(ack_cnt);
            if (sat_inc(ack_cnt) == ACK_MAX) begin
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        end
        WAIT_DONE_LO: begin
          if (!sdram_busy) begin
            if (!we_q) rdata_q[15:0] <= sdram_rdata;
            state <= ISSUE_HI;
          end
        end
        WAIT_DONE_HI: begin
          if (!sdram_busy) begin
            if (!we_q) rdata_q[31:16] <= sdram_rdata;
            state <= RESP;
          end
        end
        RESP: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed bench for sdram_host_bridge: a simple SDRAM controller model, a
// word-level reference model with expectation queues, and a per-cycle checker.
`timescale 1ns/1ps
module tb_sdram_host_bridge;
  localparam int HW = 24;
  localparam int AW = HW - 1;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [HW-1:0] sdram_haddr;
  logic [15:0]   sdram_wdata;
  logic [15:0]   sdram_rdata;
  logic          sdram_busy;
  logic          rd_en;
  logic          wr_en;

  sdram_host_bridge_if #(.HADDR_WIDTH(HW)) host();

  sdram_host_bridge #(.HADDR_WIDTH(HW), .ACK_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host            (host),
    .sdram_haddr     (sdram_haddr),
    .sdram_wdata     (sdram_wdata),
    .sdram_rdata     (sdram_rdata),
    .sdram_busy      (sdram_busy),
    .sdram_rd_enable (rd_en),
    .sdram_wr_enable (wr_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: accepts an enable while idle, stays busy busy_len cycles.
  int          busy_len = 5;
  bit          ack_en = 1'b1;
  bit          refresh = 1'b0;
  bit          pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [15:0] pl_data = 16'h0;
  int          busy_cnt = 0;
  logic [7:0]  cacc_addr = 8'h0;
  logic        cacc_rd = 1'b0;
  logic [15:0] rdata_r = 16'h0;
  logic [15:0] cmem [0:255];

  assign sdram_busy  = (busy_cnt != 0) || refresh;
  assign sdram_rdata = rdata_r;

  always @(posedge clk) begin
    if (pl_en) cmem[pl_addr] <= pl_data;
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1 && cacc_rd) rdata_r <= cmem[cacc_addr];
    end else if ((rd_en || wr_en) && !sdram_busy && ack_en) begin
      busy_cnt  <= busy_len;
      cacc_addr <= sdram_haddr[7:0];
      cacc_rd   <= rd_en;
      if (wr_en) cmem[sdram_haddr[7:0]] <= sdram_wdata;
    end
  end

  // Word-level reference model.
  typedef struct packed {
    logic          we;
    logic [HW-1:0] haddr;
    logic [15:0]   wdata;
  } acc_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  acc_t        acc_q[$];
  rsp_t        rsp_q[$];
  acc_t        log_q[$];
  int          log_cyc_q[$];
  logic [15:0] ref_mem [0:255];
  logic [31:0] last_rd = 32'h0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_model(input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    logic [HW-1:0] lo;
    logic [HW-1:0] hi;
    lo = HW'(a) + HW'(a);
    hi = lo + HW'(1);
    acc_q.push_back('{we: we, haddr: lo, wdata: d[15:0]});
    if (!ack_en) begin
      rsp_q.push_back('{rdata: last_rd, err: 1'b1});
    end else begin
      acc_q.push_back('{we: we, haddr: hi, wdata: d[31:16]});
      if (we) begin
        ref_mem[lo[7:0]] = d[15:0];
        ref_mem[hi[7:0]] = d[31:16];
      end else begin
        last_rd = {ref_mem[hi[7:0]], ref_mem[lo[7:0]]};
      end
      rsp_q.push_back('{rdata: last_rd, err: 1'b0});
    end
  endtask

  // Per-cycle checker, sampling on the falling edge.
  int          accepts = 0;
  int          hs_cyc = 0;
  int          rsp_seen = 0;
  int          rsp_cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  bit          prev_en = 1'b0;
  bit          prev_rsp = 1'b0;
  acc_t        mon_got;
  acc_t        mon_ea;
  rsp_t        mon_er;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_en  = 1'b0;
      prev_rsp = 1'b0;
    end else begin
      if (rd_en || wr_en) begin
        mon_got.we    = wr_en;
        mon_got.haddr = sdram_haddr;
        mon_got.wdata = sdram_wdata;
        log_q.push_back(mon_got);
        log_cyc_q.push_back(cyc);
        chk("en_width", 64'(prev_en), 64'd0);
        chk("en_exclusive", 64'(rd_en & wr_en), 64'd0);
        chk("en_while_busy", 64'(sdram_busy), 64'd0);
        chk("acc_expected", 64'(acc_q.size() != 0), 64'd1);
        if (acc_q.size() != 0) begin
          mon_ea = acc_q.pop_front();
          chk("acc_we", 64'(mon_got.we), 64'(mon_ea.we));
          chk("acc_haddr", 64'(mon_got.haddr), 64'(mon_ea.haddr));
          if (mon_ea.we) chk("acc_wdata", 64'(mon_got.wdata), 64'(mon_ea.wdata));
        end
      end
      prev_en = rd_en | wr_en;
      chk("err_outside_rsp", 64'(host.rsp_err & ~host.rsp_valid), 64'd0);
      if (host.rsp_valid) begin
        chk("rsp_width", 64'(prev_rsp), 64'd0);
        chk("ready_in_rsp", 64'(host.req_ready), 64'd0);
        rsp_seen++;
        rsp_cyc    = cyc;
        last_rdata = host.rsp_rdata;
        last_err   = host.rsp_err;
        chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          mon_er = rsp_q.pop_front();
          chk("rsp_rdata", 64'(host.rsp_rdata), 64'(mon_er.rdata));
          chk("rsp_err", 64'(host.rsp_err), 64'(mon_er.err));
        end
      end
      prev_rsp = host.rsp_valid;
      if (host.req_valid && host.req_ready) begin
        accepts++;
        hs_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic send(input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    int n0;
    int b;
    n0 = accepts;
    b  = 0;
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_addr  = a;
    host.req_wdata = d;
    push_model(we, a, d);
    while (accepts == n0 && b < 200) begin step(); b++; end
    chk("accept_seen", 64'(accepts != n0), 64'd1);
    host.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string name);
    int b;
    b = 0;
    while (rsp_seen < target && b < 400) begin step(); b++; end
    chk(name, 64'(rsp_seen >= target), 64'd1);
  endtask

  initial begin
    int n0;
    int r0;
    int a0;
    int b;
    int drop_cyc;
    host.req_valid = 1'b0;
    host.req_we    = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(host.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(host.rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(host.rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(host.rsp_rdata), 64'd0);
    chk("rst_haddr", 64'(sdram_haddr), 64'd0);
    chk("rst_wdata", 64'(sdram_wdata), 64'd0);
    chk("rst_enables", 64'({rd_en, wr_en}), 64'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 64'(host.req_ready), 64'd1);

    // Write 0xDEADBEEF to word 0x12345
    n0 = log_q.size();
    r0 = rsp_seen;
    send(1'b1, 23'h12345, 32'hDEADBEEF);
    wait_rsp(r0 + 1, "wr_rsp_seen");
    chk("wr_pulses", 64'(log_q.size() - n0), 64'd2);
    if (log_q.size() >= n0 + 2) begin
      chk("wr1_haddr", 64'(log_q[n0].haddr), 64'h2468A);
      chk("wr1_wdata", 64'(log_q[n0].wdata), 64'hBEEF);
      chk("wr1_is_write", 64'(log_q[n0].we), 64'd1);
      chk("wr2_haddr", 64'(log_q[n0+1].haddr), 64'h2468B);
      chk("wr2_wdata", 64'(log_q[n0+1].wdata), 64'hDEAD);
    end
    chk("wr_err", 64'(last_err), 64'd0);

    // Read word 0x10 from preloaded halfwords
    preload(8'h20, 16'h1111);
    preload(8'h21, 16'h2222);
    n0 = log_q.size();
    r0 = rsp_seen;
    send(1'b0, 23'h00010, 32'h0);
    wait_rsp(r0 + 1, "rd_rsp_seen");
    chk("rd_pulses", 64'(log_q.size() - n0), 64'd2);
    if (log_q.size() >= n0 + 2) begin
      chk("rd1_haddr", 64'(log_q[n0].haddr), 64'h20);
      chk("rd2_haddr", 64'(log_q[n0+1].haddr), 64'h21);
      chk("rd1_is_read", 64'(log_q[n0].we), 64'd0);
    end
    chk("rd_rdata", 64'(last_rdata), 64'h22221111);
    chk("rd_err", 64'(last_err), 64'd0);

    // Read back the written word
    r0 = rsp_seen;
    send(1'b0, 23'h12345, 32'h0);
    wait_rsp(r0 + 1, "rdback_rsp_seen");
    chk("rdback_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // Refresh: controller busy for 20 cycles across the accept
    refresh = 1'b1;
    n0 = log_q.size();
    r0 = rsp_seen;
    send(1'b0, 23'h00010, 32'h0);
    repeat (20) step();
    chk("refresh_no_enable", 64'(log_q.size() - n0), 64'd0);
    refresh  = 1'b0;
    drop_cyc = cyc;
    wait_rsp(r0 + 1, "refresh_rsp_seen");
    if (log_cyc_q.size() > n0) chk("refresh_first_en", 64'(log_cyc_q[n0]), 64'(drop_cyc + 1));
    chk("refresh_rdata", 64'(last_rdata), 64'h22221111);

    // Controller never acknowledges
    ack_en = 1'b0;
    n0 = log_q.size();
    r0 = rsp_seen;
    send(1'b0, 23'h00055, 32'h0);
    wait_rsp(r0 + 1, "to_rsp_seen");
    chk("to_pulses", 64'(log_q.size() - n0), 64'd1);
    chk("to_latency", 64'(rsp_cyc - hs_cyc - 1), 64'd17);
    chk("to_err", 64'(last_err), 64'd1);
    chk("to_rdata_held", 64'(last_rdata), 64'h22221111);
    step();
    chk("to_ready", 64'(host.req_ready), 64'd1);
    ack_en = 1'b1;

    // Asynchronous reset while the HI access is in progress
    n0 = log_q.size();
    send(1'b0, 23'h00010, 32'h0);
    b = 0;
    while (log_q.size() < n0 + 2 && b < 200) begin step(); b++; end
    chk("mr_hi_issued", 64'(log_q.size() - n0), 64'd2);
    b = 0;
    while (!sdram_busy && b < 50) begin step(); b++; end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_enables", 64'({rd_en, wr_en}), 64'd0);
    chk("mr_rsp_valid", 64'(host.rsp_valid), 64'd0);
    chk("mr_rsp_err", 64'(host.rsp_err), 64'd0);
    chk("mr_ready", 64'(host.req_ready), 64'd1);
    chk("mr_acc_left", 64'(acc_q.size()), 64'd0);
    rsp_q.delete();
    acc_q.delete();
    last_rd = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mr_ready_after", 64'(host.req_ready), 64'd1);
    r0 = rsp_seen;
    repeat (15) step();
    chk("mr_no_rsp", 64'(rsp_seen - r0), 64'd0);

    // Back-to-back: req_valid held high across a write and a read
    r0 = rsp_seen;
    a0 = accepts;
    host.req_valid = 1'b1;
    host.req_we    = 1'b1;
    host.req_addr  = 23'h00007;
    host.req_wdata = 32'hCAFEF00D;
    push_model(1'b1, 23'h00007, 32'hCAFEF00D);
    b = 0;
    while (accepts == a0 && b < 200) begin step(); b++; end
    host.req_we    = 1'b0;
    host.req_wdata = 32'h0;
    push_model(1'b0, 23'h00007, 32'h0);
    b = 0;
    while (accepts < a0 + 2 && b < 200) begin step(); b++; end
    host.req_valid = 1'b0;
    chk("b2b_accepts", 64'(accepts - a0), 64'd2);
    chk("b2b_first_rsp_before", 64'(rsp_seen - r0), 64'd1);
    chk("b2b_accept_cycle", 64'(hs_cyc), 64'(rsp_cyc + 1));
    wait_rsp(r0 + 2, "b2b_rsp_seen");
    chk("b2b_rdata", 64'(last_rdata), 64'hCAFEF00D);

    repeat (3) step();
    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
